u409_autoconfig: RTL and testbench

- AUTOCONFIG responder for the three U409 logical boards: the PCI bridge register window (Z2, 64k), the LIDE/ATA window (Z2, 128k) and the Prometheus-style PCI window (Z3, 512MB).
- Answers CPU reads in the $E8xxxx space with nibble ROM data and captures the base addresses Kickstart writes.
- Drives the BRIDGE_BASE, LIDE_BASE, PRO_BASE and CONFIGURED inputs of the U409 address decoder.
- Sits between the decoder's AUTOCONFIG_SPACE output and the 68040 data/transfer-acknowledge path.

---
 rtl/u409_autoconfig_if.sv | 22 ++
 rtl/u409_autoconfig.sv | 149 ++++++++++++++
 tb/tb_u409_autoconfig.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/u409_autoconfig_if.sv
// CPU-side AUTOCONFIG bus bundle for the U409 responder: decoder select,
// 68040 transfer control, config-space address and the D[31:24] data lane.
interface u409_autoconfig_if;
    logic       AUTOCONFIG_SPACE;
    logic       TSn;
    logic       RnW;
    logic [6:0] A;
    logic [7:0] D_IN;
    logic [3:0] D_OUT;
    logic       D_OE;
    logic       TACKn;

    modport master (
        output AUTOCONFIG_SPACE, TSn, RnW, A, D_IN,
        input  D_OUT, D_OE, TACKn
    );

    modport slave (
        input  AUTOCONFIG_SPACE, TSn, RnW, A, D_IN,
        output D_OUT, D_OE, TACKn
    );
endinterface

// File: rtl/u409_autoconfig.sv
// AUTOCONFIG responder for the three U409 boards (bridge, LIDE, Prometheus):
// serves nibble ROM reads and captures the base addresses Kickstart assigns.
module u409_autoconfig #(
    parameter logic [15:0] MFG_ID      = 16'h082C,
    parameter logic [7:0]  BRIDGE_PROD = 8'h01,
    parameter logic [7:0]  LIDE_PROD   = 8'h02,
    parameter logic [7:0]  PRO_PROD    = 8'h03
) (
    input  logic                     CLK40,
    input  logic                     RESETn,
    u409_autoconfig_if.slave         bus,
    output logic                     CFGOUTn,
    output logic                     CONFIGURED,
    output logic [7:0]               BRIDGE_BASE,
    output logic [6:0]               LIDE_BASE,
    output logic [2:0]               PRO_BASE
);

    typedef enum logic [1:0] {CH_BRIDGE, CH_LIDE, CH_PRO, CH_DONE} chain_t;
    typedef enum logic [1:0] {CY_IDLE, CY_WAIT, CY_ACK} cyc_t;

    chain_t     r_chain, w_chain_nxt;
    cyc_t       r_cyc, w_cyc_nxt;
    logic       r_phase;
    logic [6:0] r_a;
    logic       r_rnw;
    logic [3:0] r_lownib;
    logic [7:0] r_bridge_base;
    logic [6:0] r_lide_base;
    logic [2:0] r_pro_base;

    logic [7:0] w_off;
    logic       w_start, w_commit, w_cfg, w_shut, w_adv;
    logic [7:0] w_type, w_prod, w_flags;
    logic [3:0] w_nib;
    logic       w_unused_din;

    // Only the high nibble of the data lane carries AUTOCONFIG write data.
    assign w_unused_din = ^bus.D_IN[3:0];

    assign w_off    = {r_a, 1'b0};
    assign w_start  = (r_cyc == CY_IDLE) && !bus.TSn && bus.AUTOCONFIG_SPACE
                      && (r_chain != CH_DONE);
    assign w_commit = (r_cyc == CY_WAIT) && r_phase && !r_rnw;
    assign w_cfg    = w_commit &&
                      (((w_off == 8'h48) && ((r_chain == CH_BRIDGE) || (r_chain == CH_LIDE))) ||
                       ((w_off == 8'h44) && (r_chain == CH_PRO)));
    assign w_shut   = w_commit && (w_off == 8'h4C);
    assign w_adv    = w_cfg || w_shut;

    always_ff @(posedge CLK40) begin
        if (!RESETn) begin
            r_chain <= CH_BRIDGE;
            r_cyc   <= CY_IDLE;
        end else begin
            r_chain <= w_chain_nxt;
            r_cyc   <= w_cyc_nxt;
        end
    end

    always_comb begin
        w_chain_nxt = r_chain;
        if (w_adv) begin
            case (r_chain)
                CH_BRIDGE: w_chain_nxt = CH_LIDE;
                CH_LIDE:   w_chain_nxt = CH_PRO;
                default:   w_chain_nxt = CH_DONE;
            endcase
        end
    end

    // WAIT spans two clocks (r_phase 0 then 1) so TACKn lands two edges after TS.
    always_comb begin
        w_cyc_nxt = r_cyc;
        case (r_cyc)
            CY_IDLE: if (w_start) w_cyc_nxt = CY_WAIT;
            CY_WAIT: if (r_phase) w_cyc_nxt = CY_ACK;
            default: w_cyc_nxt = CY_IDLE;
        endcase
    end

    always_ff @(posedge CLK40) begin
        if (!RESETn) begin
            r_phase       <= 1'b0;
            r_a           <= '0;
            r_rnw         <= 1'b0;
            r_lownib      <= '0;
            r_bridge_base <= '0;
            r_lide_base   <= '0;
            r_pro_base    <= '0;
        end else begin
            r_phase <= (r_cyc == CY_WAIT) && !r_phase;
            if (w_start) begin
                r_a   <= bus.A;
                r_rnw <= bus.RnW;
            end
            if (w_adv)
                r_lownib <= '0;
            else if (w_commit && (w_off == 8'h4A) &&
                     ((r_chain == CH_BRIDGE) || (r_chain == CH_LIDE)))
                r_lownib <= bus.D_IN[7:4];
            if (w_cfg && (r_chain == CH_BRIDGE))
                r_bridge_base <= {bus.D_IN[7:4], r_lownib};
            if (w_cfg && (r_chain == CH_LIDE))
                r_lide_base <= {bus.D_IN[7:4], r_lownib[3:1]};
            if (w_cfg && (r_chain == CH_PRO))
                r_pro_base <= bus.D_IN[7:5];
        end
    end

    always_comb begin
        case (r_chain)
            CH_BRIDGE: begin w_type = 8'hC1; w_prod = BRIDGE_PROD; w_flags = 8'h00; end
            CH_LIDE:   begin w_type = 8'hC2; w_prod = LIDE_PROD;   w_flags = 8'h00; end
            CH_PRO:    begin w_type = 8'h85; w_prod = PRO_PROD;    w_flags = 8'h30; end
            default:   begin w_type = 8'h00; w_prod = 8'h00;       w_flags = 8'h00; end
        endcase
    end

    // er_type is stored true; every other ROM nibble reads back inverted.
    always_comb begin
        case (w_off)
            8'h00:   w_nib = w_type[7:4];
            8'h02:   w_nib = w_type[3:0];
            8'h04:   w_nib = ~w_prod[7:4];
            8'h06:   w_nib = ~w_prod[3:0];
            8'h08:   w_nib = ~w_flags[7:4];
            8'h0A:   w_nib = ~w_flags[3:0];
            8'h10:   w_nib = ~MFG_ID[15:12];
            8'h12:   w_nib = ~MFG_ID[11:8];
            8'h14:   w_nib = ~MFG_ID[7:4];
            8'h16:   w_nib = ~MFG_ID[3:0];
            default: w_nib = 4'hF;
        endcase
    end

    always_comb begin
        bus.TACKn  = (r_cyc != CY_ACK);
        bus.D_OE   = r_rnw && (((r_cyc == CY_WAIT) && r_phase) || (r_cyc == CY_ACK));
        bus.D_OUT  = bus.D_OE ? w_nib : 4'h0;
        CONFIGURED = (r_chain == CH_DONE);
        CFGOUTn    = (r_chain != CH_DONE);
    end

    assign BRIDGE_BASE = r_bridge_base;
    assign LIDE_BASE   = r_lide_base;
    assign PRO_BASE    = r_pro_base;

endmodule

// File: tb/tb_u409_autoconfig.sv
// Bench for u409_autoconfig: directed test-plan steps followed by random
// AUTOCONFIG traffic, each compared against a behavioural board-chain model.
module tb_u409_autoconfig;

    logic       CLK40 = 1'b0;
    logic       RESETn;
    logic       CFGOUTn, CONFIGURED;
    logic [7:0] BRIDGE_BASE;
    logic [6:0] LIDE_BASE;
    logic [2:0] PRO_BASE;

    u409_autoconfig_if bus();

    u409_autoconfig dut (
        .CLK40       (CLK40),
        .RESETn      (RESETn),
        .bus         (bus),
        .CFGOUTn     (CFGOUTn),
        .CONFIGURED  (CONFIGURED),
        .BRIDGE_BASE (BRIDGE_BASE),
        .LIDE_BASE   (LIDE_BASE),
        .PRO_BASE    (PRO_BASE)
    );

    always #12 CLK40 = ~CLK40;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: board index 0..2 for bridge/LIDE/Prometheus, 3 once the chain is done.
    int m_board;
    int m_low;
    int m_bb, m_lb, m_pb;

    function automatic int m_rom(input int board, input int byte_off);
        int er_type[3]  = '{'hC1, 'hC2, 'h85};
        int er_flags[3] = '{'h00, 'h00, 'h30};
        int mfg = 'h082C;
        int prod = board + 1;
        case (byte_off)
            'h00: return er_type[board] / 16;
            'h02: return er_type[board] % 16;
            'h04: return 15 - prod / 16;
            'h06: return 15 - prod % 16;
            'h08: return 15 - er_flags[board] / 16;
            'h0A: return 15 - er_flags[board] % 16;
            'h10: return 15 - (mfg / 4096) % 16;
            'h12: return 15 - (mfg / 256) % 16;
            'h14: return 15 - (mfg / 16) % 16;
            'h16: return 15 - mfg % 16;
            default: return 15;
        endcase
    endfunction

    task automatic m_reset();
        m_board = 0; m_low = 0; m_bb = 0; m_lb = 0; m_pb = 0;
    endtask

    task automatic m_write(input int byte_off, input int d);
        int hi = d / 16;
        bit next = 0;
        if (byte_off == 'h4A && m_board < 2) m_low = hi;
        if (byte_off == 'h48 && m_board == 0) begin m_bb = hi * 16 + m_low; next = 1; end
        if (byte_off == 'h48 && m_board == 1) begin m_lb = hi * 8 + m_low / 2; next = 1; end
        if (byte_off == 'h44 && m_board == 2) begin m_pb = d / 32; next = 1; end
        if (byte_off == 'h4C) next = 1;
        if (next) begin m_board++; m_low = 0; end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_outputs();
        chk("bridge_base", BRIDGE_BASE, m_bb);
        chk("lide_base",   LIDE_BASE,   m_lb);
        chk("pro_base",    PRO_BASE,    m_pb);
        chk("configured",  CONFIGURED,  m_board == 3);
        chk("cfgout_n",    CFGOUTn,     m_board != 3);
    endtask

    task automatic do_reset();
        RESETn = 1'b0;
        bus.TSn = 1'b1;
        bus.AUTOCONFIG_SPACE = 1'b0;
        @(negedge CLK40);
        @(negedge CLK40);
        RESETn = 1'b1;
        m_reset();
        chk("rst_tack_n", bus.TACKn, 1);
        chk("rst_d_oe",   bus.D_OE,  0);
        chk("rst_d_out",  bus.D_OUT, 0);
        chk_outputs();
    endtask

    // One CPU cycle; checks timing/data edge by edge, then commits to the model.
    task automatic run_cycle(input bit rnw, input logic [6:0] a, input logic [7:0] d);
        bit acc = (m_board != 3);
        int exp_nib = acc ? m_rom(m_board, int'(a) * 2) : 0;
        @(negedge CLK40);
        bus.TSn = 1'b0; bus.AUTOCONFIG_SPACE = 1'b1;
        bus.RnW = rnw; bus.A = a; bus.D_IN = d;
        @(negedge CLK40);
        bus.TSn = 1'b1;
        chk("tack_n_e0", bus.TACKn, 1);
        chk("d_oe_e0",   bus.D_OE,  0);
        @(negedge CLK40);
        chk("tack_n_e1", bus.TACKn, 1);
        chk("d_oe_e1",   bus.D_OE,  acc && rnw);
        if (acc && rnw) chk("d_out_e1", bus.D_OUT, exp_nib);
        @(negedge CLK40);
        chk("tack_n_e2", bus.TACKn, !acc);
        chk("d_oe_e2",   bus.D_OE,  acc && rnw);
        if (acc && rnw) chk("d_out_e2", bus.D_OUT, exp_nib);
        if (acc && !rnw) m_write(int'(a) * 2, int'(d));
        @(negedge CLK40);
        chk("tack_n_e3", bus.TACKn, 1);
        chk("d_oe_e3",   bus.D_OE,  0);
        bus.AUTOCONFIG_SPACE = 1'b0;
        chk_outputs();
    endtask

    initial begin
        RESETn = 1'b0;
        bus.TSn = 1'b1; bus.AUTOCONFIG_SPACE = 1'b0;
        bus.RnW = 1'b1; bus.A = '0; bus.D_IN = '0;
        m_reset();
        do_reset();

        // Bridge ROM reads, then full configuration of all three boards.
        run_cycle(1, 7'h00, 8'h00);
        run_cycle(1, 7'h01, 8'h00);
        run_cycle(1, 7'h08, 8'h00);
        run_cycle(1, 7'h09, 8'h00);
        run_cycle(1, 7'h18, 8'h00);
        run_cycle(0, 7'h25, 8'h50);
        run_cycle(0, 7'h24, 8'hE0);
        chk("bridge_e5", BRIDGE_BASE, 8'hE5);
        run_cycle(1, 7'h01, 8'h00);
        run_cycle(0, 7'h22, 8'hFF);
        run_cycle(0, 7'h25, 8'hA0);
        run_cycle(0, 7'h24, 8'hE0);
        chk("lide_75", LIDE_BASE, 7'b1110101);
        run_cycle(1, 7'h00, 8'h00);
        run_cycle(1, 7'h05, 8'h00);
        run_cycle(0, 7'h25, 8'hF0);
        run_cycle(0, 7'h22, 8'h40);
        chk("pro_2", PRO_BASE, 3'b010);
        chk("configured_done", CONFIGURED, 1);
        run_cycle(1, 7'h00, 8'h00);

        // Shutup all three boards; further cycles are ignored.
        do_reset();
        run_cycle(0, 7'h25, 8'hF0);
        run_cycle(0, 7'h26, 8'h00);
        run_cycle(0, 7'h26, 8'h00);
        run_cycle(0, 7'h26, 8'h00);
        run_cycle(1, 7'h00, 8'h00);
        run_cycle(0, 7'h24, 8'hE0);

        // Reset during the WAIT of a LIDE base write.
        do_reset();
        run_cycle(0, 7'h24, 8'h10);
        run_cycle(0, 7'h25, 8'hA0);
        @(negedge CLK40);
        bus.TSn = 1'b0; bus.AUTOCONFIG_SPACE = 1'b1;
        bus.RnW = 1'b0; bus.A = 7'h24; bus.D_IN = 8'hE0;
        @(negedge CLK40);
        bus.TSn = 1'b1;
        @(negedge CLK40);
        RESETn = 1'b0;
        @(negedge CLK40);
        chk("midrst_tack_n", bus.TACKn, 1);
        chk("midrst_d_oe",   bus.D_OE,  0);
        RESETn = 1'b1;
        bus.AUTOCONFIG_SPACE = 1'b0;
        m_reset();
        @(negedge CLK40);
        chk("midrst_tack_n2", bus.TACKn, 1);
        chk_outputs();
        run_cycle(1, 7'h01, 8'h00);

        // Random traffic against the model.
        for (int i = 0; i < 80; i++) begin
            int op = $urandom_range(0, 11);
            logic [7:0] d = 8'($urandom);
            logic [6:0] ra = 7'($urandom);
            case (op)
                0, 1, 2: run_cycle(1, 7'($urandom_range(0, 11)), d);
                3:       run_cycle(1, ra, d);
                4, 5:    run_cycle(0, 7'h25, d);
                6, 7:    run_cycle(0, 7'h24, d);
                8:       run_cycle(0, 7'h22, d);
                9:       run_cycle(0, 7'h26, d);
                default: run_cycle(0, ra, d);
            endcase
            if (m_board == 3) begin
                run_cycle(1, 7'h00, d);
                do_reset();
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
